full_decoder: RTL and testbench

- Control unit of the single-core RISC-V datapath.
- Decodes opcode, funct3, funct7[5] and the ALU zero flag into an 11-bit control word.
- The control word drives register-file write, immediate generator, ALU source mux, data memory, result mux, PC mux and ALU operation.
- Internally: main decoder, ALU decoder and branch/jump logic, followed by an output register.

---
 rtl/full_decoder.sv | 154 +++++++++++++++
 tb/tb_full_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/full_decoder.sv
// full_decoder: control unit of the single-core RISC-V datapath.
// It decodes opcode, funct3, funct7[5] and the ALU zero flag into an
// 11-bit control word. The word is computed combinationally and then
// held in an output register, so it appears one cycle after its inputs.
//
// Ports:
//   clk          in   1   system clock, rising-edge active
//   reset        in   1   synchronous, active-high reset
//   zero         in   1   ALU result-equals-zero flag
//   op           in   7   instruction opcode, instr[6:0]
//   funct3       in   3   instr[14:12]
//   funct7       in   1   instr[30] (funct7 bit 5)
//   control_word out  11  registered control bundle
//
// control_word layout:
//   [10] RegWrite  [9:8] ImmSrc  [7] ALUSrc  [6] MemWrite
//   [5:4] ResultSrc  [3] PCSrc  [2:0] ALUControl
module full_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        zero,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    output logic [10:0] control_word
);

    localparam int unsigned CW_W     = 11;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned ALUCTL_W = 3;

    // Recognised opcodes
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALU operation encodings
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUCTL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

    // Main decoder outputs
    logic                reg_write;
    logic [1:0]          imm_src;
    logic                alu_src;
    logic                mem_write;
    logic [1:0]          result_src;
    logic                branch;
    logic [ALUOP_W-1:0]  alu_op;
    logic                jump;

    // ALU decoder / branch logic outputs
    logic [ALUCTL_W-1:0] alu_control;
    logic                pc_src;

    // Output register
    logic [CW_W-1:0]     control_word_d;
    logic [CW_W-1:0]     control_word_q;

    // Main decoder: opcode -> datapath controls; unknown opcodes give all zeros
    always_comb begin
        reg_write  = 1'b0;
        imm_src    = 2'b00;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 2'b00;
        branch     = 1'b0;
        alu_op     = 2'b00;
        jump       = 1'b0;
        case (op)
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OP_SW: begin
                imm_src    = 2'b01;
                alu_src    = 1'b1;
                mem_write  = 1'b1;
            end
            OP_RTYPE: begin
                reg_write  = 1'b1;
                alu_op     = 2'b10;
            end
            OP_BEQ: begin
                imm_src    = 2'b10;
                branch     = 1'b1;
                alu_op     = 2'b01;
            end
            OP_ITYPE: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                alu_op     = 2'b10;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                imm_src    = 2'b11;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder: funct3 selects the operation for R/I-type.
    // Subtraction needs op[5] so that addi with instr[30]=1 still adds.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b00: alu_control = ALU_ADD;
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // Branch/jump: take the branch target on beq-with-zero or any jal
    always_comb begin
        pc_src = (branch & zero) | jump;
    end

    // Pack the control word
    always_comb begin
        control_word_d = {reg_write, imm_src, alu_src, mem_write,
                          result_src, pc_src, alu_control};
    end

    // Output register; reset wins over decoding
    always_ff @(posedge clk) begin
        if (reset) begin
            control_word_q <= '0;
        end else begin
            control_word_q <= control_word_d;
        end
    end

    assign control_word = control_word_q;

endmodule

// File: tb/tb_full_decoder.sv
// Testbench for full_decoder: directed vectors with hand-computed control words.
module tb_full_decoder;

    logic        clk;
    logic        reset;
    logic        zero;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [10:0] control_word;

    int errors = 0;
    int checks = 0;

    full_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .zero         (zero),
        .op           (op),
        .funct3       (funct3),
        .funct7       (funct7),
        .control_word (control_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z);
        op     = o;
        funct3 = f3;
        funct7 = f7;
        zero   = z;
    endtask

    // Advance past the next rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(7'b0000011, 3'b000, 1'b0, 1'b0);
        tick();
        checks++;
        if (control_word !== 11'b00000000000) begin
            errors++;
            $display("FAIL reset: got %b expected %b", control_word, 11'b00000000000);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [6:0] v_op [3];
        logic [2:0] v_f3 [3];
        logic       v_f7 [3];
        logic       v_z  [3];
        v_op = '{7'b0000011, 7'b0000011, 7'b0000011};
        v_f3 = '{3'b000, 3'b010, 3'b111};
        v_f7 = '{1'b0, 1'b1, 1'b1};
        v_z  = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(v_op[i], v_f3[i], v_f7[i], v_z[i]);
            tick();
            checks++;
            if (control_word !== 11'b10010010000) begin
                errors++;
                $display("FAIL lw[%0d]: got %b expected %b", i, control_word, 11'b10010010000);
            end
        end
    endtask

    task automatic test_sw_default();
        logic [6:0]  v_op  [4];
        logic [2:0]  v_f3  [4];
        logic        v_f7  [4];
        logic        v_z   [4];
        logic [10:0] v_exp [4];
        v_op  = '{7'b0100011, 7'b0100011, 7'b1111111, 7'b0000000};
        v_f3  = '{3'b000, 3'b010, 3'b111, 3'b000};
        v_f7  = '{1'b0, 1'b0, 1'b1, 1'b1};
        v_z   = '{1'b0, 1'b1, 1'b0, 1'b1};
        v_exp = '{11'b00111000000, 11'b00111000000, 11'b00000000000, 11'b00000000000};
        for (int i = 0; i < 4; i++) begin
            drive(v_op[i], v_f3[i], v_f7[i], v_z[i]);
            tick();
            checks++;
            if (control_word !== v_exp[i]) begin
                errors++;
                $display("FAIL sw_default[%0d]: got %b expected %b", i, control_word, v_exp[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [2:0]  v_f3  [7];
        logic        v_f7  [7];
        logic [10:0] v_exp [7];
        v_f3  = '{3'b000, 3'b000, 3'b110, 3'b111, 3'b010, 3'b100, 3'b001};
        v_f7  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        v_exp = '{11'b10000000000, 11'b10000000001, 11'b10000000011,
                  11'b10000000010, 11'b10000000101, 11'b10000000100,
                  11'b10000000000};
        for (int i = 0; i < 7; i++) begin
            drive(7'b0110011, v_f3[i], v_f7[i], 1'b0);
            tick();
            checks++;
            if (control_word !== v_exp[i]) begin
                errors++;
                $display("FAIL rtype[%0d]: got %b expected %b", i, control_word, v_exp[i]);
            end
        end
    endtask

    task automatic test_beq();
        drive(7'b1100011, 3'b000, 1'b0, 1'b1);
        tick();
        checks++;
        if (control_word !== 11'b01000001001) begin
            errors++;
            $display("FAIL beq_taken: got %b expected %b", control_word, 11'b01000001001);
        end
        drive(7'b1100011, 3'b000, 1'b0, 1'b0);
        tick();
        checks++;
        if (control_word !== 11'b01000000001) begin
            errors++;
            $display("FAIL beq_not_taken: got %b expected %b", control_word, 11'b01000000001);
        end
    endtask

    task automatic test_addi_jal();
        drive(7'b0010011, 3'b000, 1'b1, 1'b0);
        tick();
        checks++;
        if (control_word !== 11'b10010000000) begin
            errors++;
            $display("FAIL addi_f7: got %b expected %b", control_word, 11'b10010000000);
        end
        drive(7'b0010011, 3'b100, 1'b1, 1'b0);
        tick();
        checks++;
        if (control_word !== 11'b10010000100) begin
            errors++;
            $display("FAIL xori: got %b expected %b", control_word, 11'b10010000100);
        end
        drive(7'b1101111, 3'b000, 1'b0, 1'b0);
        tick();
        checks++;
        if (control_word !== 11'b11100101000) begin
            errors++;
            $display("FAIL jal: got %b expected %b", control_word, 11'b11100101000);
        end
        drive(7'b1101111, 3'b101, 1'b1, 1'b1);
        tick();
        checks++;
        if (control_word !== 11'b11100101000) begin
            errors++;
            $display("FAIL jal_zero: got %b expected %b", control_word, 11'b11100101000);
        end
    endtask

    // Inputs changing between edges must not reach the output early
    task automatic test_latency();
        drive(7'b0000011, 3'b000, 1'b0, 1'b0);
        tick();
        drive(7'b0100011, 3'b000, 1'b0, 1'b0);
        #2;
        checks++;
        if (control_word !== 11'b10010010000) begin
            errors++;
            $display("FAIL latency_hold: got %b expected %b", control_word, 11'b10010010000);
        end
        tick();
        checks++;
        if (control_word !== 11'b00111000000) begin
            errors++;
            $display("FAIL latency_update: got %b expected %b", control_word, 11'b00111000000);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        drive(7'b1101111, 3'b000, 1'b0, 1'b0);
        tick();
        checks++;
        if (control_word !== 11'b00000000000) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b", control_word, 11'b00000000000);
        end
        tick();
        checks++;
        if (control_word !== 11'b00000000000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", control_word, 11'b00000000000);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (control_word !== 11'b11100101000) begin
            errors++;
            $display("FAIL reset_resume: got %b expected %b", control_word, 11'b11100101000);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(7'b0000000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_lw();
        test_sw_default();
        test_rtype();
        test_beq();
        test_addi_jal();
        test_latency();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
